// File: rtl/udp_rx_frame_ctrl.sv
// Per-frame receive sequencer: walks Ethernet/IP/UDP headers on the MAC byte
// stream, validates the UDP header and forwards the payload of accepted frames.
module udp_rx_frame_ctrl #(
  parameter int unsigned ETH_HDR_LEN = 14,
  parameter int unsigned IP_HDR_LEN  = 20,
  parameter int unsigned UDP_HDR_LEN = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  input  logic             eth_type_ip_valid,
  input  logic             ip_header_valid,
  input  logic [15:0]      udp_port,
  output logic             ip_hdr_en,
  output logic [7:0]       payload_data,
  output logic             payload_valid,
  output logic             payload_last,
  output logic             frame_ok,
  output logic             frame_drop,
  output logic [CNT_W-1:0] ok_count,
  output logic [CNT_W-1:0] drop_count,
  output logic [2:0]       state_pin
);

  localparam int unsigned IDX_W = 8;
  localparam int unsigned LEN_W = 16;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ETH_HDR  = 3'd1,
    S_IP_HDR   = 3'd2,
    S_UDP_HDR  = 3'd3,
    S_PAYLOAD  = 3'd4,
    S_WAIT_END = 3'd5,
    S_DROP     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic               ip_ok_q, ip_ok_d;
  logic [15:0]        dst_port_q, dst_port_d;
  logic [LEN_W-1:0]   udp_len_q, udp_len_d;
  logic [7:0]         payload_data_q, payload_data_d;
  logic               payload_valid_q, payload_valid_d;
  logic               payload_last_q, payload_last_d;
  logic               frame_ok_q, frame_ok_d;
  logic               frame_drop_q, frame_drop_d;
  logic [CNT_W-1:0]   ok_count_q, ok_count_d;
  logic [CNT_W-1:0]   drop_count_q, drop_count_d;
  logic               ip_ok_now;
  logic               udp_accept;

  // IP verdict may land on the same cycle as the final UDP header byte
  assign ip_ok_now  = ip_ok_q | ip_header_valid;
  assign udp_accept = ip_ok_now && (dst_port_q == udp_port) &&
                      (udp_len_q >= LEN_W'(UDP_HDR_LEN));

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    remaining_d     = remaining_q;
    ip_ok_d         = ip_ok_q;
    dst_port_d      = dst_port_q;
    udp_len_d       = udp_len_q;
    payload_data_d  = '0;
    payload_valid_d = 1'b0;
    payload_last_d  = 1'b0;
    frame_ok_d      = 1'b0;
    frame_drop_d    = 1'b0;
    ok_count_d      = ok_count_q;
    drop_count_d    = drop_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (data_valid) begin
          state_d = S_ETH_HDR;
          idx_d   = IDX_W'(1);
        end
      end
      S_ETH_HDR: begin
        if (!data_valid) begin
          frame_drop_d = 1'b1;
          state_d      = S_IDLE;
        end else if (idx_q == IDX_W'(ETH_HDR_LEN - 1)) begin
          state_d = S_IP_HDR;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_IP_HDR: begin
        if (!data_valid) begin
          frame_drop_d = 1'b1;
          state_d      = S_IDLE;
        end else if (idx_q == '0 && !eth_type_ip_valid) begin
          frame_drop_d = 1'b1;
          state_d      = S_DROP;
        end else if (idx_q == IDX_W'(IP_HDR_LEN - 1)) begin
          state_d = S_UDP_HDR;
          idx_d   = '0;
          ip_ok_d = 1'b0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_UDP_HDR: begin
        if (!data_valid) begin
          frame_drop_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          ip_ok_d = ip_ok_now;
          // Destination port and length fields, big-endian
          if (idx_q == IDX_W'(2)) dst_port_d[15:8] = data_in;
          if (idx_q == IDX_W'(3)) dst_port_d[7:0]  = data_in;
          if (idx_q == IDX_W'(4)) udp_len_d[15:8]  = data_in;
          if (idx_q == IDX_W'(5)) udp_len_d[7:0]   = data_in;
          if (idx_q == IDX_W'(UDP_HDR_LEN - 1)) begin
            if (!udp_accept) begin
              frame_drop_d = 1'b1;
              state_d      = S_DROP;
            end else if (udp_len_q == LEN_W'(UDP_HDR_LEN)) begin
              frame_ok_d = 1'b1;
              state_d    = S_WAIT_END;
            end else begin
              remaining_d = udp_len_q - LEN_W'(UDP_HDR_LEN);
              state_d     = S_PAYLOAD;
            end
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      S_PAYLOAD: begin
        if (!data_valid) begin
          frame_drop_d = 1'b1;
          state_d      = S_IDLE;
        end else begin
          payload_data_d  = data_in;
          payload_valid_d = 1'b1;
          remaining_d     = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) begin
            payload_last_d = 1'b1;
            frame_ok_d     = 1'b1;
            state_d        = S_WAIT_END;
          end
        end
      end
      S_WAIT_END, S_DROP: begin
        if (!data_valid) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Saturating statistics
    if (frame_ok_d && (ok_count_q != '1))     ok_count_d   = ok_count_q + CNT_W'(1);
    if (frame_drop_d && (drop_count_q != '1)) drop_count_d = drop_count_q + CNT_W'(1);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q         <= S_IDLE;
      idx_q           <= '0;
      remaining_q     <= '0;
      ip_ok_q         <= 1'b0;
      dst_port_q      <= '0;
      udp_len_q       <= '0;
      payload_data_q  <= '0;
      payload_valid_q <= 1'b0;
      payload_last_q  <= 1'b0;
      frame_ok_q      <= 1'b0;
      frame_drop_q    <= 1'b0;
      ok_count_q      <= '0;
      drop_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      remaining_q     <= remaining_d;
      ip_ok_q         <= ip_ok_d;
      dst_port_q      <= dst_port_d;
      udp_len_q       <= udp_len_d;
      payload_data_q  <= payload_data_d;
      payload_valid_q <= payload_valid_d;
      payload_last_q  <= payload_last_d;
      frame_ok_q      <= frame_ok_d;
      frame_drop_q    <= frame_drop_d;
      ok_count_q      <= ok_count_d;
      drop_count_q    <= drop_count_d;
    end
  end

  // Section enable is a decode of the state register so it lines up with data_in
  assign ip_hdr_en     = (state_q == S_IP_HDR);
  assign payload_data  = payload_data_q;
  assign payload_valid = payload_valid_q;
  assign payload_last  = payload_last_q;
  assign frame_ok      = frame_ok_q;
  assign frame_drop    = frame_drop_q;
  assign ok_count      = ok_count_q;
  assign drop_count    = drop_count_q;
  assign state_pin     = state_q;

endmodule

// File: tb/tb_udp_rx_frame_ctrl.sv
// Bench for udp_rx_frame_ctrl: directed and random frames checked against a
// frame-level reference model; a narrow-counter instance covers saturation.
module tb_udp_rx_frame_ctrl;

  localparam logic [15:0] PORT = 16'h1F90;
  localparam int unsigned HDR_END = 42;  // first payload byte index

  logic        aclk = 1'b0;
  logic        areset;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        eth_type_ip_valid;
  logic        ip_header_valid;
  logic [15:0] udp_port;

  logic        ip_hdr_en, payload_valid, payload_last, frame_ok, frame_drop;
  logic [7:0]  payload_data;
  logic [15:0] ok_count, drop_count;
  logic [2:0]  state_pin;

  logic        s_ip_hdr_en, s_payload_valid, s_payload_last, s_frame_ok, s_frame_drop;
  logic [7:0]  s_payload_data;
  logic [1:0]  s_ok_count, s_drop_count;
  logic [2:0]  s_state_pin;

  int total = 0;
  int bad   = 0;
  int exp_ok, exp_drop, exp_ok_s, exp_drop_s;
  logic [7:0] fb[$];

  always #5 aclk = ~aclk;

  udp_rx_frame_ctrl dut (
    .aclk(aclk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
    .eth_type_ip_valid(eth_type_ip_valid), .ip_header_valid(ip_header_valid),
    .udp_port(udp_port), .ip_hdr_en(ip_hdr_en), .payload_data(payload_data),
    .payload_valid(payload_valid), .payload_last(payload_last),
    .frame_ok(frame_ok), .frame_drop(frame_drop), .ok_count(ok_count),
    .drop_count(drop_count), .state_pin(state_pin)
  );

  udp_rx_frame_ctrl #(.CNT_W(2)) dut_s (
    .aclk(aclk), .areset(areset), .data_in(data_in), .data_valid(data_valid),
    .eth_type_ip_valid(eth_type_ip_valid), .ip_header_valid(ip_header_valid),
    .udp_port(udp_port), .ip_hdr_en(s_ip_hdr_en), .payload_data(s_payload_data),
    .payload_valid(s_payload_valid), .payload_last(s_payload_last),
    .frame_ok(s_frame_ok), .frame_drop(s_frame_drop), .ok_count(s_ok_count),
    .drop_count(s_drop_count), .state_pin(s_state_pin)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame image: 34 random Eth/IP bytes, UDP header, payload, padding
  task automatic build(input logic [15:0] dst, input logic [15:0] len,
                       input int npay, input int npad);
    fb.delete();
    for (int i = 0; i < 36; i++) fb.push_back(8'($urandom));
    fb.push_back(dst[15:8]); fb.push_back(dst[7:0]);
    fb.push_back(len[15:8]); fb.push_back(len[7:0]);
    fb.push_back(8'($urandom)); fb.push_back(8'($urandom));
    for (int i = 0; i < npay + npad; i++) fb.push_back(8'($urandom));
  endtask

  task automatic count_ok();
    exp_ok++;
    if (exp_ok_s < 3) exp_ok_s++;
  endtask

  task automatic count_drop();
    exp_drop++;
    if (exp_drop_s < 3) exp_drop_s++;
  endtask

  // Sends n bytes of fb followed by idle cycles and checks every cycle
  task automatic run_frame(input string name, input int n, input bit eth_ok, input int ipv_k);
    int dec_k, p_lo, p_hi, last_k, pl;
    bit dec_ok, ipok, exp_ip;
    logic [15:0] port, len;
    dec_k = -1; dec_ok = 0; p_lo = 0; p_hi = 0; last_k = -1;
    port = {fb[36], fb[37]};
    len  = {fb[38], fb[39]};
    ipok = (ipv_k >= 34) && (ipv_k <= 41);
    if (n < 15) dec_k = n;
    else if (!eth_ok) dec_k = 14;
    else if (n < int'(HDR_END)) dec_k = n;
    else if (!ipok || port != udp_port || len < 16'd8) dec_k = 41;
    else if (len == 16'd8) begin dec_k = 41; dec_ok = 1; end
    else begin
      pl = int'(len) - 8;
      p_lo = HDR_END;
      if (n >= int'(HDR_END) + pl) begin
        p_hi = HDR_END + pl; last_k = p_hi - 1; dec_k = last_k; dec_ok = 1;
      end else begin
        p_hi = n; dec_k = n;
      end
    end

    for (int k = 0; k <= n + 2; k++) begin
      data_valid        = (k < n);
      data_in           = (k < n) ? fb[k] : 8'h00;
      ip_header_valid   = (k == ipv_k);
      eth_type_ip_valid = eth_ok;
      exp_ip = (k >= 14) && (k <= 33) && (k <= n) && ((k == 14) || eth_ok);
      chk($sformatf("%s k=%0d ip_hdr_en", name, k), 32'(ip_hdr_en), 32'(exp_ip));
      @(posedge aclk); #1;
      chk($sformatf("%s k=%0d payload_valid", name, k), 32'(payload_valid),
          32'((k >= p_lo) && (k < p_hi)));
      if ((k >= p_lo) && (k < p_hi))
        chk($sformatf("%s k=%0d payload_data", name, k), 32'(payload_data), 32'(fb[k]));
      chk($sformatf("%s k=%0d payload_last", name, k), 32'(payload_last), 32'(k == last_k));
      chk($sformatf("%s k=%0d frame_ok", name, k), 32'(frame_ok), 32'((k == dec_k) && dec_ok));
      chk($sformatf("%s k=%0d frame_drop", name, k), 32'(frame_drop), 32'((k == dec_k) && !dec_ok));
    end
    ip_header_valid = 1'b0;
    if (dec_ok) count_ok(); else count_drop();
    chk({name, " ok_count"},     32'(ok_count),     32'(exp_ok));
    chk({name, " drop_count"},   32'(drop_count),   32'(exp_drop));
    chk({name, " s_ok_count"},   32'(s_ok_count),   32'(exp_ok_s));
    chk({name, " s_drop_count"}, 32'(s_drop_count), 32'(exp_drop_s));
  endtask

  task automatic check_all_zero(input string name);
    chk({name, " payload_valid"}, 32'(payload_valid), 32'h0);
    chk({name, " payload_last"},  32'(payload_last),  32'h0);
    chk({name, " payload_data"},  32'(payload_data),  32'h0);
    chk({name, " frame_ok"},      32'(frame_ok),      32'h0);
    chk({name, " frame_drop"},    32'(frame_drop),    32'h0);
    chk({name, " ip_hdr_en"},     32'(ip_hdr_en),     32'h0);
    chk({name, " ok_count"},      32'(ok_count),      32'h0);
    chk({name, " drop_count"},    32'(drop_count),    32'h0);
    chk({name, " state_pin"},     32'(state_pin),     32'h0);
    chk({name, " s_ok_count"},    32'(s_ok_count),    32'h0);
  endtask

  initial begin
    logic [15:0] dst, len;
    int npay, npad, n, ipv, r;
    bit eth;

    areset = 1'b1; data_in = '0; data_valid = 1'b0;
    eth_type_ip_valid = 1'b0; ip_header_valid = 1'b0; udp_port = PORT;
    exp_ok = 0; exp_drop = 0; exp_ok_s = 0; exp_drop_s = 0;
    repeat (2) @(posedge aclk);
    #1;
    check_all_zero("reset");
    areset = 1'b0;
    @(posedge aclk); #1;

    build(PORT, 16'h000C, 4, 0);
    fb[34] = 8'h12; fb[35] = 8'h34; fb[40] = 8'h00; fb[41] = 8'h00;
    fb[42] = 8'hAA; fb[43] = 8'hBB; fb[44] = 8'hCC; fb[45] = 8'hDD;
    run_frame("good", fb.size(), 1'b1, 35);

    build(16'h1F91, 16'h000C, 4, 0);
    run_frame("port_mismatch", fb.size(), 1'b1, 35);

    build(PORT, 16'h000C, 4, 0);
    run_frame("no_ip_valid", fb.size(), 1'b1, -1);

    build(PORT, 16'h000C, 4, 0);
    run_frame("eth_fail", fb.size(), 1'b0, 35);

    build(PORT, 16'h000C, 4, 0);
    run_frame("truncate", 44, 1'b1, 35);

    build(PORT, 16'h0009, 1, 20);
    run_frame("len9_pad", fb.size(), 1'b1, 41);

    build(PORT, 16'h0008, 0, 0);
    run_frame("len8", fb.size(), 1'b1, 34);

    build(PORT, 16'h0005, 0, 3);
    run_frame("len5", fb.size(), 1'b1, 36);

    for (int f = 0; f < 60; f++) begin
      r   = $urandom_range(0, 9);
      dst = ($urandom_range(0, 4) == 0) ? 16'($urandom) : PORT;
      if (r == 0)      len = 16'($urandom_range(0, 7));
      else if (r == 1) len = 16'd8;
      else             len = 16'($urandom_range(9, 40));
      npay = (len > 16'd8) ? int'(len) - 8 : 0;
      npad = $urandom_range(0, 4);
      build(dst, len, npay, npad);
      eth = ($urandom_range(0, 9) != 0);
      ipv = ($urandom_range(0, 7) == 0) ? $urandom_range(28, 45) : $urandom_range(34, 41);
      n = fb.size();
      if ($urandom_range(0, 5) == 0) n = $urandom_range(1, fb.size());
      run_frame($sformatf("rand%0d", f), n, eth, ipv);
    end

    // Reset while payload is streaming
    build(PORT, 16'd32, 24, 0);
    for (int k = 0; k < 46; k++) begin
      data_valid = 1'b1; data_in = fb[k];
      ip_header_valid = (k == 35); eth_type_ip_valid = 1'b1;
      @(posedge aclk); #1;
    end
    chk("pre_reset payload_valid", 32'(payload_valid), 32'h1);
    areset = 1'b1; data_valid = 1'b0; ip_header_valid = 1'b0;
    @(posedge aclk); #1;
    check_all_zero("mid_reset");
    areset = 1'b0;
    exp_ok = 0; exp_drop = 0; exp_ok_s = 0; exp_drop_s = 0;
    @(posedge aclk); #1;
    build(PORT, 16'h000A, 2, 1);
    run_frame("after_reset", fb.size(), 1'b1, 38);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
